// File: rtl/reg_file_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Multi-port register file with an integrated pending-write
//            scoreboard. Reads are combinational with optional same-cycle
//            write forwarding; busy_cnt tracks the number of pending registers.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NREGS)-1:0]      wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic                          iss_en,
  input  logic [$clog2(NREGS)-1:0]      iss_addr,
  input  logic                          flush,
  output logic [$clog2(NREGS):0]        busy_cnt
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt;
  logic             wr_ok;
  logic             iss_ok;
  logic             cnt_inc;
  logic             cnt_dec;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_ok  = wr_en  && !((ZERO_R0 != 0) && (wr_addr  == '0));
  assign iss_ok = iss_en && !((ZERO_R0 != 0) && (iss_addr == '0));

  // The count moves only when a pending bit actually flips; an issue and a
  // write to the same register leave it set, so the write must not decrement.
  assign cnt_inc = iss_ok && !pend[iss_addr];
  assign cnt_dec = wr_ok && pend[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

  // Next pending vector: write clears, issue sets (issue wins), flush clears all.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok)  pend_nxt[wr_addr]  = 1'b0;
    if (iss_ok) pend_nxt[iss_addr] = 1'b1;
    if (flush)  pend_nxt = '0;
  end

  // Storage array: asynchronous clear, single write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NREGS; j++) regs[j] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard bits and running population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      if (flush) cnt <= '0;
      else       cnt <= cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  assign busy_cnt = cnt;

  // Independent read ports; a forwarded write makes the port see the new
  // data and a non-busy source in the same cycle.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          is_zero;
    logic          fwd;
    assign a       = rd_addr[i*AW +: AW];
    assign is_zero = (ZERO_R0 != 0) && (a == '0);
    assign fwd     = (BYPASS != 0) && wr_ok && (wr_addr == a);
    assign rd_data[i*XLEN +: XLEN] = is_zero ? '0 : (fwd ? wr_data : regs[a]);
    assign rd_busy[i]              = !is_zero && !fwd && pend[a];
  end

endmodule
`default_nettype wire
